// File: rtl/jtpang_palmix.sv
// jtpang_palmix: priority layer mixer with two-byte palette fetch and blanking-aligned RGB
module jtpang_palmix #(
  parameter int LAYERS = 2,
  parameter int PXLW   = 11,
  parameter int CW     = 4,
  parameter int TRANSP = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pxl_cen,
  input  logic                   LHBL,
  input  logic                   LVBL,
  input  logic                   video_enb,
  input  logic [LAYERS-1:0]      layer_en,
  input  logic                   dim,
  input  logic [LAYERS*PXLW-1:0] layer_pxl,
  input  logic                   pal_cs,
  input  logic                   wr_n,
  input  logic [PXLW:0]          cpu_addr,
  input  logic [7:0]             cpu_dout,
  output logic [7:0]             pal_dout,
  output logic                   LHBL_dly,
  output logic                   LVBL_dly,
  output logic [CW-1:0]          red,
  output logic [CW-1:0]          green,
  output logic [CW-1:0]          blue
);
  typedef enum logic [1:0] {IDLE, RD0, RD1, DONE} st_t;
  st_t st_q, st_d;
  logic [7:0] mem [0:2**(PXLW+1)-1];
  logic [7:0] vid_q, pal_dout_q, b0_q, b0_d;
  logic [PXLW-1:0] idx_q, idx_d, win;
  logic [3*CW-1:0] col, nxt_q, nxt_d, rgb_q, rgb_d;
  logic dim_q, dim_d, blank_q, blank_d, lhbl_q, lhbl_d, lvbl_q, lvbl_d;
  logic hdly_q, hdly_d, vdly_q, vdly_d;
  // palette RAM: CPU read/write port and read-only video port, both with registered reads
  always_ff @(posedge clk) begin
    if (pal_cs && !wr_n) mem[{cpu_addr[0], cpu_addr[PXLW:1]}] <= cpu_dout;
    pal_dout_q <= mem[{cpu_addr[0], cpu_addr[PXLW:1]}];
    vid_q      <= mem[{st_q == RD1, idx_q}];
  end
  // lowest enabled non-transparent layer wins; the last layer is the fallback
  always_comb begin
    win = layer_pxl[(LAYERS-1)*PXLW +: PXLW];
    for (int k = LAYERS-1; k >= 0; k--)
      if (layer_en[k] && layer_pxl[k*PXLW +: 4] != 4'(TRANSP)) win = layer_pxl[k*PXLW +: PXLW];
  end
  // fetch sequencer; a pixel enable restarts the fetch and presents the last complete colour
  always_comb begin
    st_d    = st_q;
    idx_d   = idx_q;
    dim_d   = dim_q;
    blank_d = blank_q;
    lhbl_d  = lhbl_q;
    lvbl_d  = lvbl_q;
    b0_d    = b0_q;
    nxt_d   = nxt_q;
    rgb_d   = rgb_q;
    hdly_d  = hdly_q;
    vdly_d  = vdly_q;
    col     = (3*CW)'({vid_q, b0_q});
    case (st_q)
      RD0: st_d = RD1;
      RD1: begin
        b0_d = vid_q;
        st_d = DONE;
      end
      DONE: begin
        nxt_d = dim_q ? {col[3*CW-1:2*CW] >> 1, col[2*CW-1:CW] >> 1, col[CW-1:0] >> 1} : col;
        st_d  = IDLE;
      end
      default: ;
    endcase
    if (pxl_cen) begin
      idx_d   = win;
      dim_d   = dim;
      blank_d = ~LHBL | ~LVBL | video_enb;
      lhbl_d  = LHBL;
      lvbl_d  = LVBL;
      st_d    = RD0;
      rgb_d   = blank_q ? '0 : nxt_q;
      hdly_d  = lhbl_q;
      vdly_d  = lvbl_q;
    end
  end
  // state and pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= IDLE;
      idx_q   <= '0;
      dim_q   <= 1'b0;
      blank_q <= 1'b0;
      lhbl_q  <= 1'b0;
      lvbl_q  <= 1'b0;
      b0_q    <= '0;
      nxt_q   <= '0;
      rgb_q   <= '0;
      hdly_q  <= 1'b0;
      vdly_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      idx_q   <= idx_d;
      dim_q   <= dim_d;
      blank_q <= blank_d;
      lhbl_q  <= lhbl_d;
      lvbl_q  <= lvbl_d;
      b0_q    <= b0_d;
      nxt_q   <= nxt_d;
      rgb_q   <= rgb_d;
      hdly_q  <= hdly_d;
      vdly_q  <= vdly_d;
    end
  end
  assign pal_dout = pal_dout_q;
  assign LHBL_dly = hdly_q;
  assign LVBL_dly = vdly_q;
  assign red      = rgb_q[3*CW-1:2*CW];
  assign green    = rgb_q[2*CW-1:CW];
  assign blue     = rgb_q[CW-1:0];
endmodule

// File: tb/tb_jtpang_palmix.sv
// tb_jtpang_palmix: directed pixels and CPU accesses checked by a queue-based scoreboard
module tb_jtpang_palmix;
  logic clk = 0, rst = 0, pxl_cen = 0, LHBL = 1, LVBL = 1, video_enb = 0, dim = 0;
  logic pal_cs = 0, wr_n = 1;
  logic [1:0] layer_en = 2'b11;
  logic [21:0] layer_pxl = '0;
  logic [11:0] cpu_addr = '0;
  logic [7:0] cpu_dout = '0, pal_dout;
  logic LHBL_dly, LVBL_dly;
  logic [3:0] red, green, blue;
  logic [13:0] vid_exp_q[$];
  logic [7:0] cpu_exp_q[$];
  int vecs = 0, errs = 0;

  jtpang_palmix dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL), .video_enb(video_enb),
    .layer_en(layer_en), .dim(dim), .layer_pxl(layer_pxl), .pal_cs(pal_cs), .wr_n(wr_n),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .pal_dout(pal_dout), .LHBL_dly(LHBL_dly),
    .LVBL_dly(LVBL_dly), .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [10:0] idx, input logic b, input logic [7:0] d);
    pal_cs = 1; wr_n = 0; cpu_addr = {idx, b}; cpu_dout = d;
    @(negedge clk);
    pal_cs = 0; wr_n = 1;
  endtask

  task automatic rd(input logic [10:0] idx, input logic b, input logic [7:0] e);
    pal_cs = 1; wr_n = 1; cpu_addr = {idx, b};
    cpu_exp_q.push_back(e);
    @(negedge clk);
    pal_cs = 0;
  endtask

  // mode 1: CPU writes 0x55 to {0x012,1} on the clk the video port reads byte1
  // mode 2: reset pulse one clk into the fetch
  task automatic pix(input logic [10:0] l0, input logic [10:0] l1, input int gap, input int mode,
                     input logic [13:0] e);
    layer_pxl = {l1, l0}; pxl_cen = 1;
    vid_exp_q.push_back(e);
    @(negedge clk);
    pxl_cen = 0;
    if (mode == 2) begin rst = 1; vid_exp_q.push_back(14'h0); end
    @(negedge clk);
    rst = 0;
    if (mode == 1) begin pal_cs = 1; wr_n = 0; cpu_addr = 12'h025; cpu_dout = 8'h55; end
    repeat (gap - 2) begin @(negedge clk); pal_cs = 0; wr_n = 1; end
  endtask

  // monitor: RGB/blanking checked on every pixel-enable or reset edge, pal_dout after each CPU read
  initial forever begin
    logic v, c;
    logic [13:0] ev, gv;
    logic [7:0] ec;
    @(posedge clk);
    v = pxl_cen | rst;
    c = pal_cs & wr_n;
    #1;
    if (v) begin
      vecs++;
      gv = {red, green, blue, LHBL_dly, LVBL_dly};
      if (vid_exp_q.size() == 0) begin
        errs++;
        $display("FAIL video: unexpected output event got=%h", gv);
      end else begin
        ev = vid_exp_q.pop_front();
        if (gv !== ev) begin
          errs++;
          $display("FAIL video #%0d: got rgb=%h hdly=%b vdly=%b, want rgb=%h hdly=%b vdly=%b",
                   vecs, gv[13:2], gv[1], gv[0], ev[13:2], ev[1], ev[0]);
        end
      end
    end
    if (c) begin
      vecs++;
      if (cpu_exp_q.size() == 0) begin
        errs++;
        $display("FAIL pal_dout: unexpected read got=%h", pal_dout);
      end else begin
        ec = cpu_exp_q.pop_front();
        if (pal_dout !== ec) begin
          errs++;
          $display("FAIL pal_dout #%0d: got=%h want=%h", vecs, pal_dout, ec);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    wr(11'h012, 0, 8'hBC); wr(11'h012, 1, 8'h0A);
    wr(11'h234, 0, 8'h23); wr(11'h234, 1, 8'h01);
    wr(11'h056, 0, 8'h81); wr(11'h056, 1, 8'h0F);
    layer_pxl = {11'h0, 11'h012};
    for (int i = 0; i < 3; i++) begin
      rst = 1; pxl_cen = 1;
      vid_exp_q.push_back(14'h0);
      @(negedge clk);
    end
    rst = 0; pxl_cen = 0;
    @(negedge clk);
    pix(11'h012, 11'h000, 4, 0, {12'h000, 2'b00});
    pix(11'h01F, 11'h234, 4, 0, {12'hABC, 2'b11});
    layer_en = 2'b10;
    pix(11'h011, 11'h234, 4, 0, {12'h123, 2'b11});
    layer_en = 2'b11; dim = 1;
    pix(11'h056, 11'h000, 4, 0, {12'h123, 2'b11});
    dim = 0; LHBL = 0;
    pix(11'h056, 11'h000, 4, 0, {12'h740, 2'b11});
    LHBL = 1;
    pix(11'h012, 11'h000, 4, 0, {12'h000, 2'b01});
    pix(11'h234, 11'h000, 2, 0, {12'hABC, 2'b11});
    pix(11'h056, 11'h000, 4, 0, {12'hABC, 2'b11});
    pix(11'h012, 11'h000, 4, 1, {12'hF81, 2'b11});
    pix(11'h012, 11'h000, 4, 0, {12'hABC, 2'b11});
    video_enb = 1;
    pix(11'h234, 11'h000, 4, 0, {12'h5BC, 2'b11});
    video_enb = 0;
    pix(11'h234, 11'h000, 4, 0, {12'h000, 2'b11});
    LVBL = 0;
    pix(11'h234, 11'h000, 4, 0, {12'h123, 2'b11});
    LVBL = 1; layer_en = 2'b00;
    pix(11'h234, 11'h012, 4, 0, {12'h000, 2'b10});
    layer_en = 2'b11;
    pix(11'h234, 11'h000, 4, 0, {12'h5BC, 2'b11});
    pix(11'h056, 11'h000, 4, 2, {12'h123, 2'b11});
    pix(11'h012, 11'h000, 4, 0, {12'h000, 2'b00});
    pix(11'h234, 11'h000, 4, 0, {12'h5BC, 2'b11});
    rd(11'h012, 1, 8'h55);
    rd(11'h012, 0, 8'hBC);
    rd(11'h056, 0, 8'h81);
    repeat (3) @(negedge clk);
    if (vid_exp_q.size() != 0 || cpu_exp_q.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d video and %0d cpu pending, want 0 and 0",
               vid_exp_q.size(), cpu_exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
